// File: rtl/wts_adsr_envelope_generator.sv
`default_nettype none
// ============================================================================
//  Module      : wts_adsr_envelope_generator
//  Description : Per-channel ADSR envelope generator for the wave-table sound
//                source. Produces an amplitude envelope 0..128 that a
//                downstream multiplier applies to the channel's waveform
//                sample. The envelope advances only on `active` timing pulses.
//
//  Ports       : clk          in   system clock, all state changes on posedge
//                nreset       in   asynchronous active-low reset
//                active       in   timing enable pulse (one per 6 clk)
//                key_on       in   start note (attack)
//                key_release  in   enter release phase
//                key_off      in   immediate mute
//                envelope     out  registered envelope level 0..128
//                reg_ar/dr/sr/rr in  12-bit rates: active ticks per step
//                reg_sl       in   7-bit sustain level (decay target)
//
//  Config      : WTS_ADSR_RETRIGGER_ZERO_EN
//                  defined   : key_on clears envelope to 0 before attacking
//                              (reg_ar=0 still jumps straight to 128)
//                  undefined : key_on attacks from the current level
//
//  Revision    : 1.0  initial release
// ============================================================================
module wts_adsr_envelope_generator (
    input  logic        clk,
    input  logic        nreset,
    input  logic        active,
    input  logic        key_on,
    input  logic        key_release,
    input  logic        key_off,
    output logic [7:0]  envelope,
    input  logic [11:0] reg_ar,
    input  logic [11:0] reg_dr,
    input  logic [11:0] reg_sr,
    input  logic [11:0] reg_rr,
    input  logic [6:0]  reg_sl
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ATTACK  = 3'd1;
    localparam logic [2:0] c_ST_DECAY   = 3'd2;
    localparam logic [2:0] c_ST_SUSTAIN = 3'd3;
    localparam logic [2:0] c_ST_RELEASE = 3'd4;

    localparam logic [7:0] c_ENV_MAX = 8'd128;

    logic [2:0]  r_state;
    logic [11:0] r_cnt;
    logic [7:0]  r_env;

    logic [2:0]  w_state_nxt;
    logic [11:0] w_cnt_nxt;
    logic [7:0]  w_env_nxt;

    logic [11:0] w_rate;
    logic        w_step;
    logic [7:0]  w_env_inc;
    logic [7:0]  w_env_dec;
    logic [7:0]  w_sl;

    assign w_env_inc = r_env + 8'd1;
    assign w_env_dec = r_env - 8'd1;
    assign w_sl      = {1'b0, reg_sl};

    // Rate of the current phase, read live so register writes apply at once.
    always_comb begin
        w_rate = 12'd0;
        case (r_state)
            c_ST_ATTACK:  w_rate = reg_ar;
            c_ST_DECAY:   w_rate = reg_dr;
            c_ST_SUSTAIN: w_rate = reg_sr;
            c_ST_RELEASE: w_rate = reg_rr;
            default:      w_rate = 12'd0;
        endcase
    end

    // Widened compare so cnt+1 cannot wrap when the counter sits at 4095.
    assign w_step = (({1'b0, r_cnt} + 13'd1) >= {1'b0, w_rate});

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_env_nxt   = r_env;

        if (active) begin
            if (key_off) begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 12'd0;
                w_env_nxt   = 8'd0;
            end else if (key_on) begin
                w_cnt_nxt = 12'd0;
                if (reg_ar == 12'd0) begin
                    w_env_nxt   = c_ENV_MAX;
                    w_state_nxt = c_ST_DECAY;
                end else begin
                    w_state_nxt = c_ST_ATTACK;
`ifdef WTS_ADSR_RETRIGGER_ZERO_EN
                    w_env_nxt   = 8'd0;
`endif
                end
            end else if (key_release &&
                         ((r_state == c_ST_ATTACK) ||
                          (r_state == c_ST_DECAY)  ||
                          (r_state == c_ST_SUSTAIN))) begin
                w_state_nxt = c_ST_RELEASE;
                w_cnt_nxt   = 12'd0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        w_env_nxt = 8'd0;
                        w_cnt_nxt = 12'd0;
                    end

                    c_ST_ATTACK: begin
                        if ((r_env >= c_ENV_MAX) || (reg_ar == 12'd0)) begin
                            w_env_nxt   = c_ENV_MAX;
                            w_state_nxt = c_ST_DECAY;
                            w_cnt_nxt   = 12'd0;
                        end else if (w_step) begin
                            w_env_nxt = w_env_inc;
                            w_cnt_nxt = 12'd0;
                            // Move on the edge the peak is reached so decay
                            // timing starts immediately.
                            if (w_env_inc >= c_ENV_MAX) begin
                                w_state_nxt = c_ST_DECAY;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 12'd1;
                        end
                    end

                    c_ST_DECAY: begin
                        if (r_env <= w_sl) begin
                            w_state_nxt = c_ST_SUSTAIN;
                            w_cnt_nxt   = 12'd0;
                        end else if (reg_dr != 12'd0) begin
                            if (w_step) begin
                                w_env_nxt = w_env_dec;
                                w_cnt_nxt = 12'd0;
                                if (w_env_dec <= w_sl) begin
                                    w_state_nxt = c_ST_SUSTAIN;
                                end
                            end else begin
                                w_cnt_nxt = r_cnt + 12'd1;
                            end
                        end
                    end

                    c_ST_SUSTAIN: begin
                        // Bottoms out at 0 and stays here until a key event.
                        if ((r_env != 8'd0) && (reg_sr != 12'd0)) begin
                            if (w_step) begin
                                w_env_nxt = w_env_dec;
                                w_cnt_nxt = 12'd0;
                            end else begin
                                w_cnt_nxt = r_cnt + 12'd1;
                            end
                        end
                    end

                    c_ST_RELEASE: begin
                        if (r_env == 8'd0) begin
                            w_state_nxt = c_ST_IDLE;
                            w_cnt_nxt   = 12'd0;
                        end else if (reg_rr != 12'd0) begin
                            if (w_step) begin
                                w_env_nxt = w_env_dec;
                                w_cnt_nxt = 12'd0;
                                if (w_env_dec == 8'd0) begin
                                    w_state_nxt = c_ST_IDLE;
                                end
                            end else begin
                                w_cnt_nxt = r_cnt + 12'd1;
                            end
                        end
                    end

                    default: begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = 12'd0;
                        w_env_nxt   = 8'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 12'd0;
            r_env   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_env   <= w_env_nxt;
        end
    end

    assign envelope = r_env;

endmodule
`default_nettype wire

// File: tb/tb_wts_adsr_envelope_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wts_adsr_envelope_generator
//  Description : Self-checking bench for wts_adsr_envelope_generator. Each
//                active tick pushes its expected envelope into a scoreboard
//                queue; a monitor pops and compares 1 ns after the edge.
//                Between ticks the keys are driven to junk with active=0 to
//                confirm the envelope holds.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wts_adsr_envelope_generator;

    logic        clk = 1'b0;
    logic        nreset;
    logic        active;
    logic        key_on;
    logic        key_release;
    logic        key_off;
    logic [7:0]  envelope;
    logic [11:0] reg_ar;
    logic [11:0] reg_dr;
    logic [11:0] reg_sr;
    logic [11:0] reg_rr;
    logic [6:0]  reg_sl;

    int checks   = 0;
    int failures = 0;

    int    exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    wts_adsr_envelope_generator dut (
        .clk         (clk),
        .nreset      (nreset),
        .active      (active),
        .key_on      (key_on),
        .key_release (key_release),
        .key_off     (key_off),
        .envelope    (envelope),
        .reg_ar      (reg_ar),
        .reg_dr      (reg_dr),
        .reg_sr      (reg_sr),
        .reg_rr      (reg_rr),
        .reg_sl      (reg_sl)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Monitor: every edge that carried active=1 produces one envelope value.
    always @(posedge clk) begin
        if (active === 1'b1) begin
            #1;
            if (exp_q.size() == 0) begin
                check_val("sb_underflow", 32'd1, 32'd0);
            end else begin
                check_val(tag_q.pop_front(), {24'd0, envelope}, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input logic on, input logic rel, input logic off,
                        input int exp, input string tag);
        @(negedge clk);
        key_on      = on;
        key_release = rel;
        key_off     = off;
        active      = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        // Junk keys while inactive: any reaction here would corrupt the level.
        active      = 1'b0;
        key_on      = 1'b1;
        key_release = 1'b1;
        key_off     = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_regs(input int ar, input int dr, input int sl,
                            input int sr, input int rr);
        reg_ar = 12'(ar);
        reg_dr = 12'(dr);
        reg_sl = 7'(sl);
        reg_sr = 12'(sr);
        reg_rr = 12'(rr);
    endtask

    // Scenario 4 expected curve, k = ticks since the key_on edge.
    localparam int c_T4_REL = 2500;
    function automatic int exp4(input int k);
        int lvl;
        if (k <= 256) return k / 2;                      // +1 per 2 ticks
        if (k <= 340) return 128 - (k - 256) / 3;        // -1 per 3 ticks to 100
        if (k < c_T4_REL) return 100 - (k - 340) / 100;  // -1 per 100 ticks
        lvl = 100 - (c_T4_REL - 1 - 340) / 100;          // level frozen at release
        lvl = lvl - (k - c_T4_REL) / 4;                  // -1 per 4 ticks
        return (lvl < 0) ? 0 : lvl;
    endfunction

    int soft_base;

    initial begin
        nreset      = 1'b0;
        active      = 1'b0;
        key_on      = 1'b1;
        key_release = 1'b1;
        key_off     = 1'b0;
        set_regs(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_val("reset_env", {24'd0, envelope}, 32'd0);
        nreset  = 1'b1;
        key_on  = 1'b0;
        key_release = 1'b0;
        @(negedge clk);

        // 1: no keys, stays 0
        for (int i = 0; i < 50; i++) tick(0, 0, 0, 0, "t1_idle");

        // 2: instant attack with all rates 0, then held
        tick(1, 0, 0, 128, "t2_keyon");
        for (int i = 0; i < 50; i++) tick(0, 0, 0, 128, "t2_hold");

        // 3: release with rr=0 holds, key_off mutes
        tick(0, 1, 0, 128, "t3_release");
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 128, "t3_rel_hold");
        tick(0, 0, 1, 0, "t3_keyoff");
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, "t3_off_hold");

        // 4: full ADSR curve
        set_regs(2, 3, 100, 100, 4);
        tick(1, 0, 0, exp4(0), "t4_keyon");
        for (int k = 1; k <= 2830; k++) begin
            tick(0, (k == c_T4_REL) ? 1'b1 : 1'b0, 0, exp4(k),
                 (k <= 256) ? "t4_attack" : (k <= 340) ? "t4_decay" :
                 (k < c_T4_REL) ? "t4_sustain" : "t4_release");
        end

        // 5: instant attack, decay to sl=0, hold 0, release stays 0
        set_regs(0, 3, 0, 0, 3);
        tick(1, 0, 0, 128, "t5_keyon");
        for (int k = 1; k <= 400; k++) begin
            tick(0, 0, 0, (k >= 384) ? 0 : 128 - k / 3, "t5_decay");
        end
        tick(0, 1, 0, 0, "t5_release");
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, "t5_rel_hold");

        // 6a: sustain hold at sl, release to 0 in 300 ticks
        set_regs(1, 3, 100, 0, 3);
        tick(1, 0, 0, 0, "t6_keyon");
        for (int k = 1; k <= 250; k++) begin
            tick(0, 0, 0, (k <= 128) ? k : (k <= 212) ? 128 - (k - 128) / 3 : 100,
                 (k <= 128) ? "t6_attack" : (k <= 212) ? "t6_decay" : "t6_sustain");
        end
        tick(0, 1, 0, 100, "t6_release");
        for (int r = 1; r <= 305; r++) begin
            tick(0, 0, 0, (r >= 300) ? 0 : 100 - r / 3, "t6_rel_ramp");
        end

        // 6b: retrigger mid-attack
        tick(1, 0, 0, 0, "t6_keyon2");
        for (int k = 1; k <= 5; k++) tick(0, 0, 0, k, "t6_attack2");
`ifdef WTS_ADSR_RETRIGGER_ZERO_EN
        soft_base = 0;
`else
        soft_base = 5;
`endif
        tick(1, 0, 0, soft_base, "t6_retrigger");
        for (int k = 1; k <= 3; k++) tick(0, 0, 0, soft_base + k, "t6_retrig_att");

        // key_off beats key_on
        tick(1, 0, 1, 0, "t6_off_vs_on");
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, "t6_off_hold");

        // key_on beats key_release
        tick(1, 1, 0, 0, "t6_on_vs_rel");
        for (int k = 1; k <= 3; k++) tick(0, 0, 0, k, "t6_on_vs_rel_att");
        tick(0, 0, 1, 0, "t6_final_off");

        repeat (4) @(negedge clk);
        check_val("sb_drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
